// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rcv / frame_err strobes.
// BAUDRATE is system-clock cycles per bit (4..65535).
module uart_rx_byte #(
  parameter int unsigned BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_LOAD = 16'(BAUDRATE / 2);
  localparam logic [15:0] FULL_LOAD = 16'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_n;
  logic        rx_q1, rx_s;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n;
  logic        rcv_n, ferr_n;
  logic        tick;

  assign tick = (baud_cnt == 16'd0);

  // Metastability synchronizer; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      rcv       <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      data      <= data_n;
      rcv       <= rcv_n;
      frame_err <= ferr_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  // Next-state and strobe logic
  always_comb begin
    state_n = state;
    baud_n  = tick ? baud_cnt : (baud_cnt - 16'd1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    data_n  = data;
    rcv_n   = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          baud_n  = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            baud_n  = FULL_LOAD;
            bit_n   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_n = {rx_s, shreg[7:1]};
          bit_n   = bit_cnt + 3'd1;
          baud_n  = FULL_LOAD;
          if (bit_cnt == 3'd7) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_n  = shreg;
            rcv_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so it cannot re-trigger a frame
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at BAUDRATE=104 and at the minimum divisor of 4.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int B  = 104;
  localparam int B4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx4 = 1'b1;
  logic [7:0] data, data4;
  logic       rcv, frame_err, busy;
  logic       rcv4, frame_err4, busy4;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;
  int last_lat = -1;
  int rcv_cnt = 0, ferr_cnt = 0, both_cnt = 0, dbl_cnt = 0, busy_cyc = 0;
  int rcv4_cnt = 0, ferr4_cnt = 0;
  logic rcv_d = 1'b0, ferr_d = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_hello [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h2E, 8'h2E};

  uart_rx_byte #(.BAUDRATE(B)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .rcv(rcv), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_byte #(.BAUDRATE(B4)) dut4 (
    .clk(clk), .rst(rst), .rx(rx4),
    .data(data4), .rcv(rcv4), .frame_err(frame_err4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors sample on the falling edge
  always @(negedge clk) begin
    if (rcv) begin
      rcv_cnt  <= rcv_cnt + 1;
      last_lat <= cyc - start_cyc;
      rx_q.push_back(data);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rcv && frame_err) both_cnt <= both_cnt + 1;
    if ((rcv && rcv_d) || (frame_err && ferr_d)) dbl_cnt <= dbl_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (rcv4) rcv4_cnt <= rcv4_cnt + 1;
    if (frame_err4) ferr4_cnt <= ferr4_cnt + 1;
    rcv_d  <= rcv;
    ferr_d <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input int cycles);
    if (sel) rx4 = v; else rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first, with a selectable stop-bit level
  task automatic send(input bit sel, input logic [7:0] b, input logic stopv, input int baud);
    @(posedge clk);
    #1;
    if (!sel) start_cyc = cyc;
    drive(sel, 1'b0, baud);
    for (int i = 0; i < 8; i++) drive(sel, b[i], baud);
    drive(sel, stopv, baud);
  endtask

  initial begin
    // Reset values
    idle(3);
    check("rst_data", 32'(data), 32'h00);
    check("rst_rcv", 32'(rcv), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Single byte 'H' with latency measurement
    send(1'b0, 8'h48, 1'b1, B);
    idle(20);
    check("h_rcv_cnt", 32'(rcv_cnt), 32'd1);
    check("h_data", 32'(data), 32'h48);
    check("h_lat_in_991pm1", 32'((last_lat >= 990) && (last_lat <= 992)), 32'd1);
    check("h_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // "Hello!.." back-to-back, no idle between frames
    rx_q.delete();
    for (int i = 0; i < 8; i++) send(1'b0, exp_hello[i], 1'b1, B);
    idle(2 * B);
    check("hello_count", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx_q.size()) check($sformatf("hello_byte%0d", i), 32'(rx_q[i]), 32'(exp_hello[i]));
      else check($sformatf("hello_byte%0d_missing", i), 32'd0, 32'(exp_hello[i]) | 32'h100);
    end
    check("hello_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // 20-cycle low glitch: START rejects it after BAUDRATE/2
    busy_cyc = 0;
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 3 * B);
    check("glitch_busy_52pm1", 32'((busy_cyc >= 51) && (busy_cyc <= 53)), 32'd1);
    check("glitch_rcv_cnt", 32'(rcv_cnt), 32'd9);
    check("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("glitch_data", 32'(data), 32'h2E);
    check("glitch_busy_end", 32'(busy), 32'h0);

    // Framing error then held-low line: BREAK until rx returns high
    send(1'b0, 8'h55, 1'b0, B);
    drive(1'b0, 1'b0, 500);
    check("ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("ferr_data_kept", 32'(data), 32'h2E);
    check("ferr_no_rcv", 32'(rcv_cnt), 32'd9);
    check("break_busy", 32'(busy), 32'h1);
    drive(1'b0, 1'b1, 10);
    check("break_exit_busy", 32'(busy), 32'h0);
    send(1'b0, 8'hA3, 1'b1, B);
    idle(20);
    check("a3_rcv_cnt", 32'(rcv_cnt), 32'd10);
    check("a3_data", 32'(data), 32'hA3);
    check("a3_ferr_cnt", 32'(ferr_cnt), 32'd1);

    // Reset during bit 4 of 0x0F aborts the frame
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, B);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'(i < 4), B);
    drive(1'b0, 1'b0, B / 2);
    rst = 1'b1;
    idle(2);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rcv", 32'(rcv), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4 * B);
    check("abort_no_rcv", 32'(rcv_cnt), 32'd10);
    send(1'b0, 8'hC3, 1'b1, B);
    idle(20);
    check("c3_rcv_cnt", 32'(rcv_cnt), 32'd11);
    check("c3_data", 32'(data), 32'hC3);
    check("c3_ferr_cnt", 32'(ferr_cnt), 32'd1);

    // Minimum divisor
    send(1'b1, 8'h81, 1'b1, B4);
    idle(20);
    check("b4_rcv_cnt", 32'(rcv4_cnt), 32'd1);
    check("b4_data", 32'(data4), 32'h81);
    check("b4_ferr_cnt", 32'(ferr4_cnt), 32'd0);

    // Strobe properties over the whole run
    check("strobe_exclusive", 32'(both_cnt), 32'd0);
    check("strobe_one_cycle", 32'(dbl_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
